// File: rtl/edge_det_pkg.sv
// Shared definitions for the multi-channel edge detector: mode encodings and
// arming length.
package edge_det_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_e;

    localparam int unsigned ARM_CYCLES = 3;
    localparam int unsigned ARM_W      = 2;

endpackage

// File: rtl/edge_det_channel.sv
// One detector channel: synchroniser, optional debounce filter (EDGE_DEBOUNCE_EN),
// edge select, retriggerable stretch counter and sticky flag.
module edge_det_channel
    import edge_det_pkg::*;
#(
    parameter int unsigned STRETCH_W  = 16,
    parameter int unsigned DEBOUNCE_W = 8
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iSig,
    input  logic [1:0]            iMode,
    input  logic                  iArm,
    input  logic [STRETCH_W-1:0]  iStretch,
    input  logic [DEBOUNCE_W-1:0] iDebounce,
    input  logic                  iClear,
    output logic                  oSync,
    output logic                  oPulse,
    output logic                  oExtPulse,
    output logic                  oSticky
);

    logic                 s1_q, s2_q, p_q;
    logic                 f;
    logic                 rise, fall, det_sel, det;
    logic                 pulse_q, ext_q, sticky_q;
    logic [STRETCH_W-1:0] cnt_q;

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= iSig;
            s2_q <= s1_q;
        end
    end

`ifdef EDGE_DEBOUNCE_EN
    logic                  f_q;
    logic [DEBOUNCE_W-1:0] dcnt_q;

    // While disarmed the filter is preloaded so a held input settles without counting.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            f_q    <= 1'b0;
            dcnt_q <= '0;
        end else if (!iArm) begin
            f_q    <= s2_q;
            dcnt_q <= '0;
        end else if (s2_q == f_q) begin
            dcnt_q <= '0;
        end else if (dcnt_q == iDebounce) begin
            f_q    <= s2_q;
            dcnt_q <= '0;
        end else begin
            dcnt_q <= dcnt_q + 1'b1;
        end
    end

    assign f = f_q;
`else
    logic unused_debounce;
    assign unused_debounce = ^iDebounce;
    assign f = s2_q;
`endif

    // Disarmed, p follows the settled synchronised level so arming never sees a stale edge.
    always_ff @(posedge iClk) begin
        if (!iRst_n) p_q <= 1'b0;
        else         p_q <= iArm ? f : s2_q;
    end

    always_comb begin
        rise    = f & ~p_q;
        fall    = ~f & p_q;
        det_sel = 1'b0;
        case (mode_e'(iMode))
            MODE_OFF:  det_sel = 1'b0;
            MODE_RISE: det_sel = rise;
            MODE_FALL: det_sel = fall;
            MODE_BOTH: det_sel = rise | fall;
            default:   det_sel = 1'b0;
        endcase
        det = det_sel & iArm;
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            pulse_q  <= 1'b0;
            ext_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pulse_q <= det;
            if (det) begin
                cnt_q <= iStretch;
                ext_q <= (iStretch != '0);
            end else if (cnt_q > STRETCH_W'(1)) begin
                cnt_q <= cnt_q - 1'b1;
            end else if (cnt_q == STRETCH_W'(1)) begin
                cnt_q <= '0;
                ext_q <= 1'b0;
            end
            // Edge wins over clear so a coincident event is never lost.
            if (det)         sticky_q <= 1'b1;
            else if (iClear) sticky_q <= 1'b0;
        end
    end

    assign oSync     = f;
    assign oPulse    = pulse_q;
    assign oExtPulse = ext_q;
    assign oSticky   = sticky_q;

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector top: post-reset arming, channel array and masked
// interrupt aggregation. Optional debounce is enabled with EDGE_DEBOUNCE_EN.
module multi_edge_detector
    import edge_det_pkg::*;
#(
    parameter int unsigned CHANNELS   = 8,
    parameter int unsigned STRETCH_W  = 16,
    parameter int unsigned DEBOUNCE_W = 8
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic [CHANNELS-1:0]   iSig,
    input  logic [2*CHANNELS-1:0] iMode,
    input  logic [STRETCH_W-1:0]  iStretch,
    input  logic [DEBOUNCE_W-1:0] iDebounce,
    input  logic [CHANNELS-1:0]   iClear,
    input  logic [CHANNELS-1:0]   iMask,
    output logic [CHANNELS-1:0]   oSync,
    output logic [CHANNELS-1:0]   oPulse,
    output logic [CHANNELS-1:0]   oExtPulse,
    output logic [CHANNELS-1:0]   oSticky,
    output logic                  oIrq
);

    logic [ARM_W-1:0] arm_q;
    logic             armed;
    logic             irq_q;

    assign armed = (arm_q == ARM_W'(ARM_CYCLES));

    always_ff @(posedge iClk) begin
        if (!iRst_n)     arm_q <= '0;
        else if (!armed) arm_q <= arm_q + 1'b1;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        edge_det_channel #(
            .STRETCH_W  (STRETCH_W),
            .DEBOUNCE_W (DEBOUNCE_W)
        ) u_ch (
            .iClk      (iClk),
            .iRst_n    (iRst_n),
            .iSig      (iSig[c]),
            .iMode     (iMode[2*c+1 -: 2]),
            .iArm      (armed),
            .iStretch  (iStretch),
            .iDebounce (iDebounce),
            .iClear    (iClear[c]),
            .oSync     (oSync[c]),
            .oPulse    (oPulse[c]),
            .oExtPulse (oExtPulse[c]),
            .oSticky   (oSticky[c])
        );
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) irq_q <= 1'b0;
        else         irq_q <= |(oSticky & ~iMask);
    end

    assign oIrq = irq_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Scoreboard bench for multi_edge_detector: stimulus queues cycle-tagged
// expectations, a negedge monitor pops and compares them.
module tb_multi_edge_detector;

`ifdef EDGE_DEBOUNCE_EN
    localparam int DL = 1;
`else
    localparam int DL = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  sig, clr, mask;
    logic [15:0] mode;
    logic [15:0] stretch;
    logic [7:0]  deb;
    logic [7:0]  sync_o, pulse_o, ext_o, sticky_o;
    logic        irq_o;

    always #5 clk = ~clk;

    multi_edge_detector #(
        .CHANNELS   (8),
        .STRETCH_W  (16),
        .DEBOUNCE_W (8)
    ) dut (
        .iClk      (clk),
        .iRst_n    (rst_n),
        .iSig      (sig),
        .iMode     (mode),
        .iStretch  (stretch),
        .iDebounce (deb),
        .iClear    (clr),
        .iMask     (mask),
        .oSync     (sync_o),
        .oPulse    (pulse_o),
        .oExtPulse (ext_o),
        .oSticky   (sticky_o),
        .oIrq      (irq_o)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        int         sel;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic expect_at(input int at, input int sel, input logic [7:0] v, input string name);
        exp_t e;
        int   i;
        e = '{at, sel, v, name};
        i = 0;
        while (i < sb.size() && sb[i].at <= at) i++;
        sb.insert(i, e);
    endtask

    function automatic logic [7:0] actual(input int sel);
        case (sel)
            0:       return pulse_o;
            1:       return ext_o;
            2:       return sticky_o;
            3:       return {7'b0, irq_o};
            default: return sync_o;
        endcase
    endfunction

    exp_t       cur;
    logic [7:0] act;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            cur = sb.pop_front();
            act = actual(cur.sel);
            n_vec++;
            if (cur.at != cyc || act !== cur.exp) begin
                n_err++;
                $display("FAIL %s (due cyc %0d, checked cyc %0d): got %h, want %h",
                         cur.name, cur.at, cyc, act, cur.exp);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int n, k;

    initial begin
        rst_n = 1'b0; sig = 8'hFF; mode = 16'hFFFF; stretch = 16'd4;
        deb = 8'd0; clr = 8'h00; mask = 8'h00;
        step(3);
        // Reset state, then input held high through reset must not fire
        n = cyc;
        for (int s = 0; s < 5; s++) expect_at(n, s, 8'h00, $sformatf("reset_sel%0d", s));
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) expect_at(n + i, 0, 8'h00, "no_pulse_after_release");
        expect_at(n + 12, 2, 8'h00, "no_sticky_after_release");
        expect_at(n + 5, 4, 8'hFF, "sync_high");
        step(13);

        mode = 16'h0000; sig = 8'h00;
        step(6);
        expect_at(cyc, 2, 8'h00, "mode_off_no_sticky");
        step(1);

        // ch0 rising, stretch 4
        mode = 16'h0001; n = cyc; sig[0] = 1'b1;
        expect_at(n + 2 + DL, 0, 8'h00, "rise_pulse_before");
        expect_at(n + 3 + DL, 0, 8'h01, "rise_pulse");
        expect_at(n + 4 + DL, 0, 8'h00, "rise_pulse_one_cycle");
        for (int i = 3; i <= 6; i++) expect_at(n + i + DL, 1, 8'h01, "rise_ext");
        expect_at(n + 7 + DL, 1, 8'h00, "rise_ext_end");
        expect_at(n + 3 + DL, 2, 8'h01, "rise_sticky");
        expect_at(n + 3 + DL, 3, 8'h00, "irq_not_yet");
        expect_at(n + 4 + DL, 3, 8'h01, "irq_set");
        step(10);

        k = cyc; clr = 8'h01;
        expect_at(k, 2, 8'h01, "sticky_before_clear");
        expect_at(k + 1, 2, 8'h00, "sticky_cleared");
        expect_at(k + 2, 3, 8'h00, "irq_cleared");
        step(1); clr = 8'h00;
        step(4);

        // ch0 falling mode
        mode = 16'h0002; n = cyc; sig[0] = 1'b0;
        expect_at(n + 3 + DL, 0, 8'h01, "fall_pulse");
        expect_at(n + 3 + DL, 2, 8'h01, "fall_sticky");
        step(8);

        // ch1 both edges; ch0 in fall mode ignores its rise
        mode = 16'h000E; n = cyc; sig[1:0] = 2'b11;
        expect_at(n + 3 + DL, 0, 8'h02, "both_rise_pulse");
        step(6);
        n = cyc; sig[1] = 1'b0;
        expect_at(n + 3 + DL, 0, 8'h02, "both_fall_pulse");
        step(8);

        // ch2 retrigger with stretch 5
        mode = 16'h0030; stretch = 16'd5; n = cyc; sig[2] = 1'b1;
        expect_at(n + 2 + DL, 1, 8'h00, "retrig_ext_before");
        expect_at(n + 3 + DL, 0, 8'h04, "retrig_pulse1");
        expect_at(n + 4 + DL, 0, 8'h00, "retrig_pulse_gap");
        expect_at(n + 6 + DL, 0, 8'h04, "retrig_pulse2");
        for (int i = 3; i <= 10; i++) expect_at(n + i + DL, 1, 8'h04, "retrig_ext");
        expect_at(n + 11 + DL, 1, 8'h00, "retrig_ext_end");
        step(3); sig[2] = 1'b0;
        step(12);

        stretch = 16'd0; n = cyc; sig[2] = 1'b1;
        expect_at(n + 3 + DL, 0, 8'h04, "zero_stretch_pulse");
        expect_at(n + 3 + DL, 1, 8'h00, "zero_stretch_no_ext");
        expect_at(n + 4 + DL, 1, 8'h00, "zero_stretch_no_ext2");
        step(8);

        clr = 8'hFF; step(1); clr = 8'h00; step(1);
        expect_at(cyc, 2, 8'h00, "clear_all");
        expect_at(cyc + 1, 3, 8'h00, "irq_after_clear_all");
        step(2);

        // Clear coincident with edge keeps sticky
        stretch = 16'd4; n = cyc; sig[2] = 1'b0;
        expect_at(n + 3 + DL, 0, 8'h04, "coincide_pulse");
        expect_at(n + 3 + DL, 2, 8'h04, "coincide_sticky_kept");
        expect_at(n + 4 + DL, 2, 8'h04, "coincide_sticky_still");
        step(2 + DL); clr = 8'h04;
        step(1); clr = 8'h00;
        step(2);
        k = cyc; clr = 8'h04;
        expect_at(k, 2, 8'h04, "clear_alone_before");
        expect_at(k + 1, 2, 8'h00, "clear_alone_after");
        step(1); clr = 8'h00;
        step(2);

        // Masked channel
        mask = 8'h04; n = cyc; sig[2] = 1'b1;
        expect_at(n + 3 + DL, 2, 8'h04, "masked_sticky");
        expect_at(n + 4 + DL, 3, 8'h00, "masked_irq");
        expect_at(n + 6 + DL, 3, 8'h00, "masked_irq_later");
        step(8);
        k = cyc; mask = 8'h00;
        expect_at(k + 1, 3, 8'h01, "unmask_irq");
        step(2);
        k = cyc; mask = 8'h04;
        expect_at(k + 1, 3, 8'h00, "remask_irq");
        expect_at(k + 1, 2, 8'h04, "remask_sticky_kept");
        step(3);

`ifdef EDGE_DEBOUNCE_EN
        deb = 8'd3; mode = 16'h0040; n = cyc; sig[3] = 1'b1;
        for (int i = 3; i <= 12; i++) expect_at(n + i, 0, 8'h00, "glitch_rejected");
        step(3); sig[3] = 1'b0;
        step(14);
        n = cyc; sig[3] = 1'b1;
        expect_at(n + 6, 0, 8'h00, "debounce_pulse_before");
        expect_at(n + 7, 0, 8'h08, "debounce_pulse");
        step(10);
        deb = 8'd0;
`endif

        // Reset during an active stretch
        mask = 8'h00; stretch = 16'd20; mode = 16'h0100; n = cyc; sig[4] = 1'b1;
        expect_at(n + 3 + DL, 0, 8'h10, "mid_pulse");
        expect_at(n + 5 + DL, 1, 8'h10, "mid_ext_active");
        step(6 + DL);
        rst_n = 1'b0; k = cyc;
        for (int s = 0; s < 5; s++) expect_at(k + 1, s, 8'h00, $sformatf("mid_reset_sel%0d", s));
        step(1); rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            expect_at(k + 1 + i, 0, 8'h00, "post_reset_no_pulse");
            expect_at(k + 1 + i, 1, 8'h00, "post_reset_no_ext");
        end
        step(14);

        for (int i = 0; i < 50 && sb.size() > 0; i++) step(1);
        if (sb.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multi_edge_detector.md
# multi_edge_detector

Parametrised multi-channel edge detector: the successor to the single-channel pulse/stretch/sticky detector used across the PDB CPLD for IO-expander interrupts and PG/alert lines. Each channel synchronises an asynchronous input, optionally debounces it, and detects rising, falling or both edges under a per-channel mode. It produces a one-cycle pulse, a retriggerable stretched pulse and a sticky flag, and aggregates the sticky flags into one maskable interrupt. Stretch timing runs in the single system clock, so no second timer clock and no asynchronous self-reset are needed.

## Interface
- CHANNELS, 8, number of independent channels (1..32)
- STRETCH_W, 16, width of stretch length and counter
- DEBOUNCE_W, 8, width of debounce length and counter (used only with the macro)

- iClk  in  1  system clock; all logic on rising edge
- iRst_n  in  1  reset, synchronous, active-low
- iSig  in  CHANNELS  asynchronous inputs
- iMode  in  2*CHANNELS  per channel [2c+1:2c]: 00 off, 01 rising, 10 falling, 11 both
- iStretch  in  STRETCH_W  stretched-pulse length in cycles, shared by all channels
- iDebounce  in  DEBOUNCE_W  stable-cycle requirement, shared by all channels
- iClear  in  CHANNELS  per-channel sticky clear, active-high, level
- iMask  in  CHANNELS  1 = channel excluded from oIrq
- oSync  out  CHANNELS  synchronised/filtered level
- oPulse  out  CHANNELS  one-cycle edge pulse
- oExtPulse  out  CHANNELS  stretched pulse
- oSticky  out  CHANNELS  latched edge flag
- oIrq  out  1  OR of (oSticky & ~iMask), registered

## Operation
- Per channel: 2-flop synchroniser s1→s2; filtered level f (= s2 without the macro); previous level p <= f every cycle.
- Edge (combinational): rise = f & ~p, fall = ~f & p; selected by iMode; mode 00 yields no edge.
- Arming: 2-bit counter after reset. Edges are suppressed until 3 cycles after iRst_n deasserts, while p tracks f. An input held high through reset produces no edge.
- oPulse <= edge (registered); high exactly one cycle per detected edge.
- Stretch: on edge, cnt <= iStretch and oExtPulse <= (iStretch != 0). Otherwise, if cnt > 1, cnt decrements. When cnt == 1, cnt <= 0 and oExtPulse <= 0.
  - oExtPulse is high for exactly iStretch cycles, starting in the same cycle as oPulse.
  - A new edge while active reloads the counter (retrigger; the pulse extends).
  - iStretch == 0: no ext pulse.
- Sticky: oSticky set in the same cycle as oPulse. It clears the cycle after iClear is sampled high. A simultaneous edge and iClear leaves the flag set, so no event is lost.
- A mode change takes effect on the next cycle and does not alter sticky or stretch state.
- oIrq <= |(oSticky & ~iMask). Masking a pending channel drops oIrq the next cycle; the sticky flag remains set.
- Reset: every register and output is 0 (oSync, oPulse, oExtPulse, oSticky, oIrq, counters, arm).

## Timing
- iSig change set up before clock edge k: s2 updates at k+1, oPulse/oExtPulse/oSticky rise at k+2 (macro off), and oIrq at k+3.
- With the macro, f updates after s2 has differed from f for iDebounce+1 consecutive edges. Add iDebounce+1 cycles to every latency above.
- Input pulses shorter than one clock may be missed (macro off) and are rejected (macro on). Minimum gap between detectable edges: 1 cycle (off) or iDebounce+1 cycles (on).

## Configuration
- EDGE_DEBOUNCE_EN defined: per-channel debounce counter (DEBOUNCE_W). The counter resets to 0 whenever s2 == f; f <= s2 when the counter reaches iDebounce. iDebounce == 0 gives a 1-cycle filter.
- Not defined: f = s2, iDebounce ignored, no counter logic.

## Structure
- Package edge_det_pkg: mode encodings (MODE_OFF/RISE/FALL/BOTH), ARM_CYCLES = 3.
- Sub-module edge_det_channel: synchroniser, filter, edge select, stretch counter, sticky. Instantiated CHANNELS times by generate; the top level holds arming and oIrq aggregation.

## Test plan
- Mode 01, iStretch=4, ch0 rises at edge k: oPulse[0] high 1 cycle at k+2; oExtPulse[0] high k+2..k+5; oSticky[0] set; oIrq=1 at k+3; mode 10/11 variants on the falling edge.
- iSig=all-ones through reset: no oPulse in any channel for 10 cycles after release.
- iStretch=5, second edge 3 cycles after the first: oExtPulse continuous for 8 cycles; iStretch=0 gives oExtPulse never high.
- iClear[2] held high in the same cycle oPulse[2] fires: oSticky[2] remains 1; iClear alone clears it next cycle; iMask[2]=1 gives oIrq=0 with sticky 1.
- EDGE_DEBOUNCE_EN, iDebounce=3: a 3-cycle glitch gives no pulse; a 4-cycle-stable level gives a pulse at latency 6.
- Reset asserted mid-stretch: all outputs 0 on the next edge, and no residual pulse after release.
